ofs_fim_emif_avmm_arb: RTL

- Two-requester Avalon-MM arbiter sharing one EMIF user port (576b data incl. ECC, 27b word address, 7b burstcount).
- Sits between two FIM/AFU memory clients and the EMIF controller, all on the EMIF user clock.
- Round-robin grant, locked for the full write burst.
- Read responses are routed back in order through a grant-order FIFO.

---
 rtl/ofs_fim_emif_cfg_pkg.sv | 23 ++
 rtl/ofs_fim_emif_rd_order_fifo.sv | 64 ++++++
 rtl/ofs_fim_emif_avmm_arb.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ofs_fim_emif_cfg_pkg.sv
// Shared EMIF user-port widths plus the types used by the two-port Avalon-MM arbiter.
package ofs_fim_emif_cfg_pkg;

    localparam int AVMM_DATA_WIDTH       = 576;
    localparam int AVMM_ADDR_WIDTH       = 27;
    localparam int AVMM_BURSTCOUNT_WIDTH = 7;
    localparam int AVMM_BYTEENABLE_WIDTH = 72;

    localparam int EMIF_ARB_NUM_PORTS    = 2;

    typedef enum logic [1:0] {
        ARB    = 2'd0,
        CMD    = 2'd1,
        WBURST = 2'd2
    } arb_state_t;

    // One entry per forwarded read: which requester owns it and how many beats come back.
    typedef struct packed {
        logic                             id;
        logic [AVMM_BURSTCOUNT_WIDTH-1:0] bcnt;
    } rd_order_t;

endpackage

// File: rtl/ofs_fim_emif_rd_order_fifo.sv
// Show-ahead FIFO of read-order entries; head is valid whenever empty is low.
module ofs_fim_emif_rd_order_fifo
    import ofs_fim_emif_cfg_pkg::*;
#(
    parameter int DEPTH = 64
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  rd_order_t wdata,
    input  logic      pop,
    output rd_order_t rdata,
    output logic      full,
    output logic      empty
);

    localparam int             AW       = $clog2(DEPTH);
    localparam logic [AW:0]    FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW-1:0]  PTR_ONE  = AW'(1);
    localparam logic [AW:0]    CNT_ONE  = (AW+1)'(1);

    rd_order_t     mem_r [DEPTH];
    logic [AW-1:0] wptr_r;
    logic [AW-1:0] rptr_r;
    logic [AW:0]   count_r;
    logic          push_ok_s;
    logic          pop_ok_s;

    assign full      = (count_r == FULL_CNT);
    assign empty     = (count_r == {(AW+1){1'b0}});
    assign pop_ok_s  = pop & ~empty;
    // A push into a full FIFO is fine when the same cycle frees the head slot.
    assign push_ok_s = push & (~full | pop_ok_s);
    assign rdata     = mem_r[rptr_r];

    // Entry storage; contents are qualified by the count, so no reset is needed.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointer and occupancy tracking.
    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_r  <= {AW{1'b0}};
            rptr_r  <= {AW{1'b0}};
            count_r <= {(AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wptr_r <= wptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rptr_r <= rptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ofs_fim_emif_avmm_arb.sv
// Two-requester round-robin Avalon-MM arbiter in front of one EMIF user port.
// Write bursts hold the grant; read data is steered back using a grant-order FIFO.
module ofs_fim_emif_avmm_arb
    import ofs_fim_emif_cfg_pkg::*;
#(
    parameter int RD_ORDER_DEPTH = 64,
    parameter int DATA_W         = ofs_fim_emif_cfg_pkg::AVMM_DATA_WIDTH,
    parameter int ADDR_W         = ofs_fim_emif_cfg_pkg::AVMM_ADDR_WIDTH,
    parameter int BCNT_W         = ofs_fim_emif_cfg_pkg::AVMM_BURSTCOUNT_WIDTH,
    parameter int BE_W           = ofs_fim_emif_cfg_pkg::AVMM_BYTEENABLE_WIDTH
) (
    input  logic              clk,
    input  logic              rst,

    input  logic [ADDR_W-1:0] s0_address,
    input  logic              s0_read,
    input  logic              s0_write,
    input  logic [BCNT_W-1:0] s0_burstcount,
    input  logic [DATA_W-1:0] s0_writedata,
    input  logic [BE_W-1:0]   s0_byteenable,
    output logic              s0_waitrequest,
    output logic [DATA_W-1:0] s0_readdata,
    output logic              s0_readdatavalid,

    input  logic [ADDR_W-1:0] s1_address,
    input  logic              s1_read,
    input  logic              s1_write,
    input  logic [BCNT_W-1:0] s1_burstcount,
    input  logic [DATA_W-1:0] s1_writedata,
    input  logic [BE_W-1:0]   s1_byteenable,
    output logic              s1_waitrequest,
    output logic [DATA_W-1:0] s1_readdata,
    output logic              s1_readdatavalid,

    output logic [ADDR_W-1:0] m_address,
    output logic              m_read,
    output logic              m_write,
    output logic [BCNT_W-1:0] m_burstcount,
    output logic [DATA_W-1:0] m_writedata,
    output logic [BE_W-1:0]   m_byteenable,
    input  logic              m_waitrequest,
    input  logic [DATA_W-1:0] m_readdata,
    input  logic              m_readdatavalid,

    output logic              err_rdv_unexp
);

    localparam int              OBW       = AVMM_BURSTCOUNT_WIDTH;
    localparam logic [BCNT_W-1:0] BCNT_ONE = BCNT_W'(1);
    localparam logic [OBW-1:0]  OBCNT_ONE = OBW'(1);

    arb_state_t              state_r;
    logic                    grant_r;
    logic                    rr_r;
    logic [BCNT_W-1:0]       beats_left_r;
    logic [OBW-1:0]          rbeat_r;
    logic                    err_r;

    logic [EMIF_ARB_NUM_PORTS-1:0] req_s;
    logic                    pick_s;
    logic                    g_read_s;
    logic                    g_write_s;
    logic [ADDR_W-1:0]       g_addr_s;
    logic [BCNT_W-1:0]       g_bcnt_s;
    logic [BCNT_W-1:0]       g_bcnt_eff_s;
    logic [DATA_W-1:0]       g_wdata_s;
    logic [BE_W-1:0]         g_be_s;
    logic                    m_read_s;
    logic                    m_write_s;
    logic                    gwait_s;
    logic                    rd_acc_s;
    logic                    wr_acc_s;

    rd_order_t               push_data_s;
    rd_order_t               head_s;
    logic                    full_s;
    logic                    empty_s;
    logic                    rdv_hit_s;
    logic                    last_beat_s;
    logic                    pop_s;

    assign req_s[0] = s0_read | s0_write;
    assign req_s[1] = s1_read | s1_write;

    // Round-robin choice among the currently requesting ports.
    always_comb begin
        if (req_s[0] && req_s[1]) begin
            pick_s = rr_r;
        end else if (req_s[1]) begin
            pick_s = 1'b1;
        end else begin
            pick_s = 1'b0;
        end
    end

    // Granted requester's command fields.
    always_comb begin
        if (grant_r) begin
            g_read_s  = s1_read;
            g_write_s = s1_write;
            g_addr_s  = s1_address;
            g_bcnt_s  = s1_burstcount;
            g_wdata_s = s1_writedata;
            g_be_s    = s1_byteenable;
        end else begin
            g_read_s  = s0_read;
            g_write_s = s0_write;
            g_addr_s  = s0_address;
            g_bcnt_s  = s0_burstcount;
            g_wdata_s = s0_writedata;
            g_be_s    = s0_byteenable;
        end
    end

    assign g_bcnt_eff_s = (g_bcnt_s == {BCNT_W{1'b0}}) ? BCNT_ONE : g_bcnt_s;

    // Command forwarding: write wins over read, reads stall while the order FIFO is full.
    always_comb begin
        m_read_s  = 1'b0;
        m_write_s = 1'b0;
        gwait_s   = 1'b1;
        case (state_r)
            CMD: begin
                if (g_write_s) begin
                    m_write_s = 1'b1;
                    gwait_s   = m_waitrequest;
                end else if (g_read_s && !full_s) begin
                    m_read_s  = 1'b1;
                    gwait_s   = m_waitrequest;
                end else begin
                    gwait_s   = 1'b1;
                end
            end
            WBURST: begin
                if (g_write_s) begin
                    m_write_s = 1'b1;
                    gwait_s   = m_waitrequest;
                end else begin
                    gwait_s   = 1'b1;
                end
            end
            default: begin
                gwait_s = 1'b1;
            end
        endcase
    end

    assign rd_acc_s = m_read_s & ~m_waitrequest;
    assign wr_acc_s = m_write_s & ~m_waitrequest;

    assign m_read         = m_read_s;
    assign m_write        = m_write_s;
    assign m_address      = g_addr_s;
    assign m_burstcount   = g_bcnt_eff_s;
    assign m_writedata    = g_wdata_s;
    assign m_byteenable   = g_be_s;
    assign s0_waitrequest = grant_r ? 1'b1 : gwait_s;
    assign s1_waitrequest = grant_r ? gwait_s : 1'b1;

    // Arbitration state machine; the grant is registered, costing one ARB cycle per grant.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ARB;
            grant_r      <= 1'b0;
            rr_r         <= 1'b0;
            beats_left_r <= {BCNT_W{1'b0}};
        end else begin
            case (state_r)
                ARB: begin
                    if (|req_s) begin
                        grant_r <= pick_s;
                        state_r <= CMD;
                    end
                end
                CMD: begin
                    if (wr_acc_s) begin
                        if (g_bcnt_eff_s == BCNT_ONE) begin
                            rr_r    <= ~rr_r;
                            state_r <= ARB;
                        end else begin
                            beats_left_r <= g_bcnt_eff_s - BCNT_ONE;
                            state_r      <= WBURST;
                        end
                    end else if (rd_acc_s) begin
                        rr_r    <= ~rr_r;
                        state_r <= ARB;
                    end else if (!g_read_s && !g_write_s) begin
                        // Requester withdrew before being served; re-arbitrate rather than hang.
                        state_r <= ARB;
                    end
                end
                WBURST: begin
                    if (wr_acc_s) begin
                        if (beats_left_r == BCNT_ONE) begin
                            rr_r    <= ~rr_r;
                            state_r <= ARB;
                        end else begin
                            beats_left_r <= beats_left_r - BCNT_ONE;
                        end
                    end
                end
                default: begin
                    state_r <= ARB;
                end
            endcase
        end
    end

    assign push_data_s.id   = grant_r;
    assign push_data_s.bcnt = OBW'(g_bcnt_eff_s);

    ofs_fim_emif_rd_order_fifo #(
        .DEPTH (RD_ORDER_DEPTH)
    ) u_rd_order_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_acc_s),
        .wdata (push_data_s),
        .pop   (pop_s),
        .rdata (head_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign rdv_hit_s   = m_readdatavalid & ~empty_s;
    assign last_beat_s = (rbeat_r == (head_s.bcnt - OBCNT_ONE));
    assign pop_s       = rdv_hit_s & last_beat_s;

    assign s0_readdata      = m_readdata;
    assign s1_readdata      = m_readdata;
    assign s0_readdatavalid = rdv_hit_s & ~head_s.id;
    assign s1_readdatavalid = rdv_hit_s & head_s.id;
    assign err_rdv_unexp    = err_r;

    // Return-beat progress for the FIFO head and the sticky orphan-response flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            rbeat_r <= {OBW{1'b0}};
            err_r   <= 1'b0;
        end else begin
            if (rdv_hit_s) begin
                rbeat_r <= last_beat_s ? {OBW{1'b0}} : (rbeat_r + OBCNT_ONE);
            end
            if (m_readdatavalid && empty_s) begin
                err_r <= 1'b1;
            end
        end
    end

endmodule
